// File: rtl/gray_ud_cnt_if.sv
// gray_ud_cnt_if: control and count bus of the up/down Gray counter
interface gray_ud_cnt_if #(parameter int CBITS = 8);
  logic en;
  logic up;
  logic ld;
  logic [CBITS-1:0] ld_val;
  logic [CBITS-1:0] bin_cnt;
  logic [CBITS-1:0] gray_cnt;
  logic sig;
  logic dir_q;
  modport master(output en, up, ld, ld_val, input bin_cnt, gray_cnt, sig, dir_q);
  modport slave(input en, up, ld, ld_val, output bin_cnt, gray_cnt, sig, dir_q);
endinterface

// File: rtl/gray_ud_cnt.sv
// gray_ud_cnt: loadable up/down binary counter with same-cycle Gray output and wrap pulse
module gray_ud_cnt #(
  parameter int CBITS = 8,
  parameter logic [31:0] RST_VAL = '0
) (
  input logic clk,
  input logic rst,
  gray_ud_cnt_if.slave bus
);
  localparam logic [CBITS-1:0] RV = RST_VAL[CBITS-1:0];
  logic [CBITS-1:0] bin, gray, nxt;
  logic sig, dir, step, wrap;
  always_comb begin
    step = bus.en && !bus.ld;
    nxt = bus.ld ? bus.ld_val : step ? (bus.up ? bin + 1'b1 : bin - 1'b1) : bin;
    wrap = step && (bus.up ? &bin : ~|bin);
  end
  // Gray is encoded from the next binary value so both registers update together
  always_ff @(posedge clk) begin
    if (rst) begin
      bin <= RV;
      gray <= RV ^ (RV >> 1);
      sig <= 1'b0;
      dir <= 1'b1;
    end else begin
      bin <= nxt;
      gray <= nxt ^ (nxt >> 1);
      sig <= wrap;
      if (step) dir <= bus.up;
    end
  end
  assign bus.bin_cnt = bin;
  assign bus.gray_cnt = gray;
  assign bus.sig = sig;
  assign bus.dir_q = dir;
endmodule

// File: tb/tb_gray_ud_cnt.sv
// tb_gray_ud_cnt: vector table and scoreboard checks for 4-bit and 8-bit counters
module tb_gray_ud_cnt;
  logic clk = 1'b0;
  logic rst4, rst8;
  always #5 clk = ~clk;
  gray_ud_cnt_if #(.CBITS(4)) i4();
  gray_ud_cnt_if #(.CBITS(8)) i8();
  gray_ud_cnt #(.CBITS(4), .RST_VAL(32'd0)) d4(.clk(clk), .rst(rst4), .bus(i4.slave));
  gray_ud_cnt #(.CBITS(8), .RST_VAL(32'hFE)) d8(.clk(clk), .rst(rst8), .bus(i8.slave));
  typedef struct {logic r, e, u, l; logic [3:0] lv, b, g; logic s, d;} vec_t;
  typedef struct {logic [7:0] b, g; logic s, d, st;} exp_t;
  int errors = 0, checks = 0;
  vec_t tv[$];
  exp_t sb[$];
  logic [3:0] gseq[16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                           4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
  task automatic cmp(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, i, act, exp);
    end
  endtask
  function automatic vec_t v(logic r, logic e, logic u, logic l, logic [3:0] lv,
                             logic [3:0] b, logic [3:0] g, logic s, logic d);
    vec_t x;
    x = '{r, e, u, l, lv, b, g, s, d};
    return x;
  endfunction
  task automatic step8(input string nm, input logic r, input logic e, input logic u,
                       input logic [7:0] eb, input logic s, input logic d);
    exp_t x;
    rst8 = r; i8.en = e; i8.up = u; i8.ld = 1'b0;
    sb.push_back('{eb, eb ^ (eb >> 1), s, d, 1'b0});
    @(posedge clk); #1;
    x = sb.pop_front();
    cmp({nm, "_bin"}, 0, 32'(i8.bin_cnt), 32'(x.b));
    cmp({nm, "_gray"}, 0, 32'(i8.gray_cnt), 32'(x.g));
    cmp({nm, "_sig"}, 0, 32'(i8.sig), 32'(x.s));
    cmp({nm, "_dir"}, 0, 32'(i8.dir_q), 32'(x.d));
  endtask
  initial begin
    exp_t x;
    logic [3:0] pg;
    logic [7:0] pg8, mb;
    int pulses;
    rst4 = 1'b1; rst8 = 1'b1;
    i4.en = 0; i4.up = 1; i4.ld = 0; i4.ld_val = '0;
    i8.en = 0; i8.up = 1; i8.ld = 0; i8.ld_val = '0;
    pg = '0;
    tv.push_back(v(1, 1, 1, 0, 4'h0, 4'h0, 4'h0, 0, 1));
    for (int k = 0; k < 16; k++)
      tv.push_back(v(0, 1, 1, 0, 4'h0, 4'(k + 1), gseq[k], k == 15, 1));
    tv.push_back(v(0, 1, 1, 0, 4'h0, 4'h1, 4'h1, 0, 1));
    tv.push_back(v(0, 1, 0, 1, 4'h5, 4'h5, 4'h7, 0, 1));
    tv.push_back(v(0, 0, 1, 1, 4'h0, 4'h0, 4'h0, 0, 1));
    tv.push_back(v(0, 1, 0, 0, 4'h0, 4'hF, 4'h8, 1, 0));
    tv.push_back(v(0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 1, 1));
    tv.push_back(v(0, 1, 1, 0, 4'h0, 4'h1, 4'h1, 0, 1));
    tv.push_back(v(0, 1, 1, 0, 4'h0, 4'h2, 4'h3, 0, 1));
    tv.push_back(v(0, 1, 1, 0, 4'h0, 4'h3, 4'h2, 0, 1));
    tv.push_back(v(0, 1, 0, 0, 4'h0, 4'h2, 4'h3, 0, 0));
    tv.push_back(v(0, 1, 0, 0, 4'h0, 4'h1, 4'h1, 0, 0));
    tv.push_back(v(0, 0, 1, 0, 4'h0, 4'h1, 4'h1, 0, 0));
    tv.push_back(v(0, 0, 1, 1, 4'hF, 4'hF, 4'h8, 0, 0));
    tv.push_back(v(1, 1, 0, 1, 4'h7, 4'h0, 4'h0, 0, 1));
    tv.push_back(v(0, 1, 1, 0, 4'h0, 4'h1, 4'h1, 0, 1));
    foreach (tv[i]) begin
      rst4 = tv[i].r; i4.en = tv[i].e; i4.up = tv[i].u; i4.ld = tv[i].l; i4.ld_val = tv[i].lv;
      sb.push_back('{{4'h0, tv[i].b}, {4'h0, tv[i].g}, tv[i].s, tv[i].d, tv[i].e & !tv[i].l & !tv[i].r});
      @(posedge clk); #1;
      x = sb.pop_front();
      cmp("bin4", i, 32'(i4.bin_cnt), 32'(x.b));
      cmp("gray4", i, 32'(i4.gray_cnt), 32'(x.g));
      cmp("sig4", i, 32'(i4.sig), 32'(x.s));
      cmp("dir4", i, 32'(i4.dir_q), 32'(x.d));
      cmp("gray4_rel", i, 32'(i4.gray_cnt), 32'(i4.bin_cnt ^ (i4.bin_cnt >> 1)));
      if (x.st) cmp("gray4_1bit", i, $countones(i4.gray_cnt ^ pg), 1);
      pg = i4.gray_cnt;
    end
    step8("r8_rst", 1, 1, 1, 8'hFE, 0, 1);
    step8("r8_ff", 0, 1, 1, 8'hFF, 0, 1);
    step8("r8_wrap", 0, 1, 1, 8'h00, 1, 1);
    step8("r8_01", 0, 1, 1, 8'h01, 0, 1);
    step8("r8_02", 0, 1, 1, 8'h02, 0, 1);
    step8("r8_03", 0, 1, 1, 8'h03, 0, 1);
    step8("r8_midrst", 1, 1, 1, 8'hFE, 0, 1);
    cmp("r8_gray81", 0, 32'(i8.gray_cnt), 32'h81);
    step8("r8_ff2", 0, 1, 1, 8'hFF, 0, 1);
    step8("r8_wrap2", 0, 1, 1, 8'h00, 1, 1);
    i8.en = 1'b0; rst8 = 1'b1; #2; rst8 = 1'b0;
    step8("r8_glitch", 0, 0, 1, 8'h00, 0, 1);
    mb = 8'h00; pg8 = i8.gray_cnt;
    for (int dir = 1; dir >= 0; dir--) begin
      pulses = 0;
      i8.en = 1'b1; i8.up = dir[0];
      for (int k = 0; k < 256; k++) begin
        @(posedge clk); #1;
        mb = dir[0] ? mb + 8'd1 : mb - 8'd1;
        if (i8.bin_cnt !== mb || i8.gray_cnt !== (mb ^ (mb >> 1)) || $countones(i8.gray_cnt ^ pg8) != 1)
          cmp("run8_step", k, {16'h0, i8.bin_cnt, i8.gray_cnt}, {16'h0, mb, mb ^ (mb >> 1)});
        pg8 = i8.gray_cnt;
        if (i8.sig === 1'b1) pulses++;
      end
      cmp("run8_bin", dir, 32'(i8.bin_cnt), 32'(mb));
      cmp("run8_pulses", dir, pulses, 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
